spike_rate_encoder: RTL and testbench

SPIKE_RATE_ENCODER -- requirements
Module: spike_rate_encoder

---
 rtl/spike_encoder_pkg.sv | 12 +
 rtl/spike_phase_accumulator.sv | 32 +++
 rtl/spike_rate_encoder.sv | 95 +++++++++
 tb/tb_spike_rate_encoder.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/spike_encoder_pkg.sv
// Shared constants for the spike rate encoder: intensity/accumulator widths
// and the controller state encoding.
package spike_encoder_pkg;

    localparam int unsigned INTENSITY_W = 6;
    localparam int unsigned ACC_W       = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/spike_phase_accumulator.sv
// One channel of the rate encoder: a phase accumulator whose carry-out is
// the spike for the step being issued.
module spike_phase_accumulator
    import spike_encoder_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   advance,
    input  logic [INTENSITY_W-1:0] intensity,
    output logic                   spike
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    // Carry out of acc + intensity marks a spike for this step
    always_comb begin
        sum   = {1'b0, acc} + {{(ACC_W + 1 - INTENSITY_W){1'b0}}, intensity};
        spike = sum[ACC_W];
    end

    // Accumulator keeps the wrapped phase; cleared on reset or window start
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            acc <= '0;
        end else if (advance) begin
            acc <= sum[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate encoder: converts per-channel 6-bit intensities into spike vectors
// over a window of num_steps time steps, one step per non-held RUN cycle.
module spike_rate_encoder
    import spike_encoder_pkg::*;
#(
    parameter int unsigned M       = 8,
    parameter int unsigned NSTEP_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [M*INTENSITY_W-1:0] intensities,
    input  logic [NSTEP_W-1:0]       num_steps,
    input  logic                     hold,
    output logic [M-1:0]             input_spikes,
    output logic                     spike_valid,
    output logic                     busy,
    output logic                     done,
    output logic [NSTEP_W-1:0]       step_count
);

    logic [1:0]               state;
    logic [M*INTENSITY_W-1:0] lat_int;
    logic [NSTEP_W-1:0]       lat_num;
    logic [NSTEP_W-1:0]       count_next;
    logic [M-1:0]             spikes;
    logic                     acc_clear;
    logic                     acc_advance;

    // Accumulator control and next step count derived from current state
    always_comb begin
        acc_clear   = (state == ST_IDLE) && start;
        acc_advance = (state == ST_RUN) && !hold;
        count_next  = step_count + 1'b1;
    end

    genvar g;
    generate
        for (g = 0; g < M; g++) begin : g_chan
            spike_phase_accumulator u_acc (
                .clk       (clk),
                .reset     (reset),
                .clear     (acc_clear),
                .advance   (acc_advance),
                .intensity (lat_int[g*INTENSITY_W +: INTENSITY_W]),
                .spike     (spikes[g])
            );
        end
    endgenerate

    // Window controller: latch on start, issue steps, pulse done for one cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            lat_int      <= '0;
            lat_num      <= '0;
            step_count   <= '0;
            input_spikes <= '0;
            spike_valid  <= 1'b0;
        end else begin
            input_spikes <= '0;
            spike_valid  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        lat_int    <= intensities;
                        lat_num    <= num_steps;
                        step_count <= '0;
                        state      <= (num_steps == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!hold) begin
                        input_spikes <= spikes;
                        spike_valid  <= 1'b1;
                        step_count   <= count_next;
                        if (count_next == lat_num) begin
                            state <= ST_DONE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status flags decoded directly from the state register
    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Self-checking bench for spike_rate_encoder. The reference model predicts
// the spike of channel i at step k as floor(k*I/64) - floor((k-1)*I/64).
module tb_spike_rate_encoder;

    localparam int unsigned M       = 8;
    localparam int unsigned NSTEP_W = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [M*6-1:0]       intensities;
    logic [NSTEP_W-1:0]   num_steps;
    logic                 hold;
    logic [M-1:0]         input_spikes;
    logic                 spike_valid;
    logic                 busy;
    logic                 done;
    logic [NSTEP_W-1:0]   step_count;

    int n_checks = 0;
    int n_pass   = 0;
    int lat_int[M];

    spike_rate_encoder #(.M(M), .NSTEP_W(NSTEP_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .intensities  (intensities),
        .num_steps    (num_steps),
        .hold         (hold),
        .input_spikes (input_spikes),
        .spike_valid  (spike_valid),
        .busy         (busy),
        .done         (done),
        .step_count   (step_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int unsigned model_spikes(input int k);
        int unsigned v = 0;
        for (int i = 0; i < M; i++)
            if ((k * lat_int[i]) / 64 != ((k - 1) * lat_int[i]) / 64) v |= (1 << i);
        return v;
    endfunction

    // hold_mode: 0 none, 1 random, 2 five cycles starting at loop cycle 8
    task automatic run_window(input logic [M*6-1:0] intens, input int n,
                              input int hold_mode, input bit disturb, input int abort_at);
        int k = 0;
        int cyc = 0;
        int cnt[M];
        bit fin;
        bit h;
        for (int i = 0; i < M; i++) begin
            cnt[i] = 0;
            lat_int[i] = int'(intens[6*i +: 6]);
        end
        @(negedge clk);
        start = 1'b1; intensities = intens; num_steps = NSTEP_W'(n); hold = 1'b0;
        @(posedge clk); #1;
        check("start_busy", busy, 1);
        check("start_done", done, (n == 0) ? 1 : 0);
        check("start_valid", spike_valid, 0);
        check("start_count", step_count, 0);
        fin = (n == 0);
        @(negedge clk);
        start = 1'b0;
        while (!fin && cyc < n + 200) begin
            if (cyc > 0) @(negedge clk);
            case (hold_mode)
                1:       h = ($urandom_range(0, 3) == 0);
                2:       h = (cyc >= 8 && cyc < 13);
                default: h = 1'b0;
            endcase
            hold = h;
            if (disturb) begin
                start = $urandom_range(0, 1) == 1;
                intensities = {$urandom, $urandom};
                num_steps = NSTEP_W'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
            if (!h) k++;
            check("valid", spike_valid, h ? 0 : 1);
            check("spikes", input_spikes, h ? 0 : model_spikes(k));
            check("count", step_count, k);
            check("done", done, (k == n) ? 1 : 0);
            check("busy", busy, 1);
            if (spike_valid)
                for (int i = 0; i < M; i++) cnt[i] += int'(input_spikes[i]);
            fin = (k == n);
            if (abort_at != 0 && k == abort_at) begin
                @(negedge clk);
                reset = 1'b0; start = 1'b0; hold = 1'b0;
                @(posedge clk); #1;
                check("abort_valid", spike_valid, 0);
                check("abort_spikes", input_spikes, 0);
                check("abort_done", done, 0);
                check("abort_busy", busy, 0);
                check("abort_count", step_count, 0);
                @(negedge clk);
                reset = 1'b1;
                return;
            end
        end
        if (!fin) check("window_timeout", 0, 1);
        @(negedge clk);
        start = 1'b0; hold = 1'b0;
        @(posedge clk); #1;
        check("end_busy", busy, 0);
        check("end_done", done, 0);
        check("end_valid", spike_valid, 0);
        check("end_count", step_count, n);
        for (int i = 0; i < M; i++)
            check($sformatf("total_ch%0d", i), cnt[i], (n * lat_int[i]) / 64);
    endtask

    initial begin
        logic [M*6-1:0] v;
        reset = 1'b0; start = 1'b0; hold = 1'b0;
        intensities = '0; num_steps = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", spike_valid, 0);
        check("rst_spikes", input_spikes, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", step_count, 0);
        @(negedge clk);
        reset = 1'b1;

        // All channels at half rate over a full 64-step window
        for (int i = 0; i < M; i++) v[6*i +: 6] = 6'd32;
        run_window(v, 64, 0, 1'b0, 0);

        // Extremes: 63, 0 and 1 on the first three channels
        v = {$urandom, $urandom};
        v[5:0] = 6'd63; v[11:6] = 6'd0; v[17:12] = 6'd1;
        run_window(v, 64, 0, 1'b0, 0);

        // Five-cycle stall in a 20-step window
        run_window({$urandom, $urandom}, 20, 2, 1'b0, 0);

        // Empty window
        run_window({$urandom, $urandom}, 0, 0, 1'b0, 0);

        // Reset at step 10, then restart with the extreme pattern
        run_window({$urandom, $urandom}, 64, 0, 1'b0, 10);
        run_window(v, 64, 0, 1'b0, 0);

        // Start and input changes during RUN must not affect the window
        run_window({$urandom, $urandom}, 64, 0, 1'b1, 0);

        // Random windows with random stalls
        for (int t = 0; t < 6; t++)
            run_window({$urandom, $urandom}, $urandom_range(1, 70), 1, t[0], 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
